// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder_if
// Brief    : Load handshake, drain control and skewed edge bus of the feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 4,
    parameter int N          = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] in_data;
    logic                    start;
    logic                    busy;
    logic                    out_valid;
    logic [N*DATA_WIDTH-1:0] out_data;
    logic                    done;

    modport master (
        output in_valid, in_data, start,
        input  in_ready, busy, out_valid, out_data, done
    );

    modport slave (
        input  in_valid, in_data, start,
        output in_ready, busy, out_valid, out_data, done
    );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder
// Brief    : Buffers N vectors, then replays them with lane i delayed i cycles.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 4,
    parameter int N          = 4
) (
    input  wire                   clk,
    input  wire                   reset,
    systolic_skew_feeder_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    localparam int TW = $clog2(2 * N - 1);
    localparam int KW = $clog2(N);
    localparam int W  = N * DATA_WIDTH;

    localparam logic [CW-1:0] c_last_beat = CW'(N - 1);
    localparam logic [TW-1:0] c_last_t    = TW'(2 * N - 2);
    localparam logic [TW:0]   c_n         = (TW + 1)'(N);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FULL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_t;
    logic            r_in_ready;
    logic            r_busy;
    logic            r_out_valid;
    logic            r_done;
    logic [W-1:0]    r_out_data;
    logic [W-1:0]    r_buf [N];

    logic            w_load_xfer;
    logic [TW-1:0]   w_t_next;
    logic [W-1:0]    w_slice;

    assign w_load_xfer = (r_state == S_LOAD) && bus.in_valid;
    // The slice registered at an edge is the one shown during the following cycle.
    assign w_t_next    = (r_state == S_DRAIN) ? (r_t + 1'b1) : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [TW:0] w_diff;
        logic        w_in_range;
        assign w_diff     = {1'b0, w_t_next} - (TW + 1)'(i);
        assign w_in_range = !w_diff[TW] && (w_diff < c_n);
        assign w_slice[i*DATA_WIDTH +: DATA_WIDTH] = w_in_range
            ? r_buf[w_diff[KW-1:0]][i*DATA_WIDTH +: DATA_WIDTH]
            : '0;
    end

    // Buffer is never cleared: out-of-window lanes are zero-filled above.
    always_ff @(posedge clk) begin
        if (!reset && w_load_xfer) begin
            r_buf[r_cnt[KW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_t         <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last_beat) begin
                            r_state    <= S_FULL;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    if (bus.start) begin
                        r_state     <= S_DRAIN;
                        r_t         <= '0;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_slice;
                    end
                end
                S_DRAIN: begin
                    if (r_t == c_last_t) begin
                        r_state     <= S_LOAD;
                        r_cnt       <= '0;
                        r_t         <= '0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_done      <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_t        <= r_t + 1'b1;
                        r_out_data <= w_slice;
                    end
                end
                default: begin
                    r_state     <= S_LOAD;
                    r_cnt       <= '0;
                    r_t         <= '0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_skew_feeder
// Brief    : Scoreboard bench for the skewed edge feeder (N=4, DATA_WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;
    localparam int DW = 4;
    localparam int N  = 4;
    localparam int W  = N * DW;
    localparam int NS = 2 * N - 1;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [W-1:0] exp_q [$];
    logic [W-1:0] mv [N];
    int           mcnt;

    systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(N)) bus ();

    systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: lane i at time t carries element i of vector t-i, else zero.
    function automatic logic [W-1:0] exp_slice(input int t);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) r[i*DW +: DW] = mv[t-i][i*DW +: DW];
        return r;
    endfunction

    task automatic push_model_drain();
        for (int t = 0; t < NS; t++) exp_q.push_back(exp_slice(t));
        mcnt = 0;
    endtask

    // Inputs change and outputs are sampled at falling edges only.
    task automatic load_vec(input logic [W-1:0] v);
        int k;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) begin
            n_fail++;
            $display("FAIL load_timeout: in_ready=%b, required 1 within 50 cycles", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (mcnt < N) begin
            mv[mcnt] = v;
            mcnt++;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.done !== 1'b0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: rdy=%b busy=%b ov=%b done=%b od=%h, required 1 0 0 0 0000",
                     bus.in_ready, bus.busy, bus.out_valid, bus.done, bus.out_data);
        end
        load_vec(16'h1111);
        load_vec(16'h2222);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mcnt = 0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.done !== 1'b0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_midload: rdy=%b busy=%b ov=%b done=%b od=%h, required 1 0 0 0 0000",
                     bus.in_ready, bus.busy, bus.out_valid, bus.done, bus.out_data);
        end
    endtask

    task automatic test_load_drain();
        logic [W-1:0] e;
        load_vec(16'h4321);
        load_vec(16'h8765);
        load_vec(16'hCBA9);
        load_vec(16'h0FED);
        mcnt = 0;
        exp_q.push_back(16'h0001); exp_q.push_back(16'h0025);
        exp_q.push_back(16'h0369); exp_q.push_back(16'h47AD);
        exp_q.push_back(16'h8BE0); exp_q.push_back(16'hCF00);
        exp_q.push_back(16'h0000);
        pulse_start();
        for (int s = 0; s < NS; s++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.out_data !== e) begin
                n_fail++;
                $display("FAIL load_drain slice %0d: ov=%b busy=%b od=%h, required 1 1 %h",
                         s, bus.out_valid, bus.busy, bus.out_data, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.busy !== 1'b0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL load_drain_done: done=%b ov=%b rdy=%b busy=%b od=%h, required 1 0 1 0 0000",
                     bus.done, bus.out_valid, bus.in_ready, bus.busy, bus.out_data);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%b one cycle after pulse, required 0", bus.done);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e;
        load_vec(16'h4321);
        load_vec(16'h8765);
        load_vec(16'hCBA9);
        load_vec(16'h0FED);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: rdy=%b busy=%b, required 0 0",
                         c, bus.in_ready, bus.busy);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        push_model_drain();
        pulse_start();
        for (int s = 0; s < NS; s++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
                n_fail++;
                $display("FAIL backpressure slice %0d: ov=%b od=%h, required 1 %h",
                         s, bus.out_valid, bus.out_data, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_done: done=%b, required 1", bus.done);
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] e;
        load_vec(16'h1A2B);
        load_vec(16'h3C4D);
        pulse_start();
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL ignored_start_load cycle %0d: busy=%b ov=%b rdy=%b, required 0 0 1",
                         c, bus.busy, bus.out_valid, bus.in_ready);
            end
            @(negedge clk);
        end
        load_vec(16'h5E6F);
        bus.start = 1'b1;
        load_vec(16'h7081);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_not_queued: busy=%b ov=%b, required 0 0", bus.busy, bus.out_valid);
        end
        push_model_drain();
        pulse_start();
        for (int s = 0; s < NS; s++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e || bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL ignored_start slice %0d: ov=%b od=%h done=%b, required 1 %h 0",
                         s, bus.out_valid, bus.out_data, bus.done, e);
            end
            bus.start = (s == 2);
            @(negedge clk);
        end
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_done: done=%b ov=%b, required 1 0", bus.done, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [W-1:0] e;
        bit           saw_done;
        for (int b = 0; b < N; b++) load_vec(W'($urandom));
        push_model_drain();
        pulse_start();
        for (int s = 0; s <= 3; s++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
                n_fail++;
                $display("FAIL mid_drain slice %0d: ov=%b od=%h, required 1 %h",
                         s, bus.out_valid, bus.out_data, e);
            end
            if (s < 3) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        mcnt = 0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b1 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: ov=%b od=%h rdy=%b busy=%b done=%b, required 0 0000 1 0 0",
                     bus.out_valid, bus.out_data, bus.in_ready, bus.busy, bus.done);
        end
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.out_valid === 1'b1) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL reset_mid_drain_quiet: done/out_valid seen=%b, required 0", saw_done);
        end
        for (int b = 0; b < N; b++) load_vec(W'($urandom));
        push_model_drain();
        pulse_start();
        for (int s = 0; s < NS; s++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
                n_fail++;
                $display("FAIL post_reset slice %0d: ov=%b od=%h, required 1 %h",
                         s, bus.out_valid, bus.out_data, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_done: done=%b, required 1", bus.done);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        for (int b = 0; b < N; b++) load_vec(16'h1111 * W'(b + 1));
        push_model_drain();
        pulse_start();
        for (int s = 0; s < NS; s++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
                n_fail++;
                $display("FAIL b2b_first slice %0d: ov=%b od=%h, required 1 %h",
                         s, bus.out_valid, bus.out_data, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_done: done=%b rdy=%b, required 1 1", bus.done, bus.in_ready);
        end
        load_vec(16'hA5C3);
        load_vec(16'h0F1E);
        load_vec(16'h7B2D);
        load_vec(16'hE9D6);
        push_model_drain();
        pulse_start();
        for (int s = 0; s < NS; s++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e) begin
                n_fail++;
                $display("FAIL b2b_second slice %0d: ov=%b od=%h, required 1 %h",
                         s, bus.out_valid, bus.out_data, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL b2b_second_done: done=%b ov=%b od=%h, required 1 0 0000",
                     bus.done, bus.out_valid, bus.out_data);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        mcnt         = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.start    = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_drain();
        test_backpressure();
        test_ignored_start();
        test_reset_mid_drain();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
